fifo_pop_arbiter: RTL and testbench

// - Reader/drain side of the switch FIFOs: pops words from NUM_IN source FIFOs and pushes them into one downstream FIFO.
// - Sits between the per-class ingress FIFOs and the egress FIFO.
// - Arbitration is round-robin (or strict priority) and honours the downstream fifo_pause flow-control signal.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_pop_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_pop_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO pop arbiter: FSM state encoding and index-width helper.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    // Index width for n sources; never below one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational priority search over req, starting at ptr and wrapping at N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap keeps non-power-of-2 N correct.
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!gnt_vld && req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Drains NUM_IN source FIFOs into one downstream FIFO: pop stage, push stage,
// round-robin or strict-priority arbitration and a saturating drop counter.
module fifo_pop_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_SIZE = 10,
    parameter int NUM_IN    = 4,
    parameter bit RR_EN     = 1'b1,
    localparam int IDX_W    = idx_w(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_IN-1:0]           in_empty,
    input  logic [NUM_IN*DATA_SIZE-1:0] in_data,
    input  logic                        out_pause,
    input  logic                        out_full,
    output logic [NUM_IN-1:0]           in_pop,
    output logic                        out_push,
    output logic [DATA_SIZE-1:0]        out_data,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        drop_err,
    output logic [7:0]                  drop_cnt,
    output arb_state_t                  fsm_state
);

    // Strobes: in_pop[i] is a one-cycle read of a non-empty source whose word
    // appears on in_data a cycle later; out_push is a one-cycle write of out_data.
    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  pick_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  pend_idx;
    logic              gnt_vld;
    logic              pend_vld;
    logic              pop_now;
    logic              any_req;
    logic [NUM_IN-1:0] req;

    assign req       = ~in_empty;
    assign any_req   = |req;
    assign pick_ptr  = RR_EN ? rr_ptr : '0;
    assign fsm_state = state;

    rr_pick #(
        .N (NUM_IN),
        .W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign pop_now = !reset && (state == ST_RUN) && !out_pause && gnt_vld;

    always_comb begin
        in_pop = '0;
        if (pop_now) begin
            in_pop[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            pend_vld  <= 1'b0;
            pend_idx  <= '0;
            out_push  <= 1'b0;
            out_data  <= '0;
            grant_idx <= '0;
            drop_err  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            pend_vld <= pop_now;
            if (pop_now) begin
                pend_idx  <= gnt_idx;
                grant_idx <= gnt_idx;
                rr_ptr    <= (gnt_idx == IDX_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
            end

            // A word in the push stage is lost if the downstream FIFO is full.
            out_push <= pend_vld && !out_full;
            drop_err <= pend_vld && out_full;
            if (pend_vld) begin
                if (out_full) begin
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end else begin
                    out_data <= in_data[pend_idx*DATA_SIZE +: DATA_SIZE];
                end
            end

            case (state)
                ST_IDLE: if (any_req) state <= ST_RUN;
                ST_RUN: begin
                    if (out_pause) begin
                        state <= ST_HOLD;
                    end else if (!any_req) begin
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: if (!out_pause) state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Bench for fifo_pop_arbiter: a round-robin and a strict-priority instance each
// drain their own modelled source FIFOs, checked cycle by cycle against a timeline model.
module tb_fifo_pop_arbiter;
    import fifo_arb_pkg::*;

    localparam int DW   = 10;
    localparam int N    = 4;
    localparam int NU   = 2;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic reset;
    logic out_pause;
    logic out_full;

    logic [N-1:0]    in_empty_u [NU];
    logic [N*DW-1:0] in_data_u  [NU];
    logic [N-1:0]    in_pop_u   [NU];
    logic            out_push_u [NU];
    logic [DW-1:0]   out_data_u [NU];
    logic [1:0]      grant_u    [NU];
    logic            derr_u     [NU];
    logic [7:0]      dcnt_u     [NU];
    arb_state_t      st_u       [NU];

    always #5 clk = ~clk;

    fifo_pop_arbiter #(.DATA_SIZE(DW), .NUM_IN(N), .RR_EN(1'b1)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .in_empty  (in_empty_u[0]),
        .in_data   (in_data_u[0]),
        .out_pause (out_pause),
        .out_full  (out_full),
        .in_pop    (in_pop_u[0]),
        .out_push  (out_push_u[0]),
        .out_data  (out_data_u[0]),
        .grant_idx (grant_u[0]),
        .drop_err  (derr_u[0]),
        .drop_cnt  (dcnt_u[0]),
        .fsm_state (st_u[0])
    );

    fifo_pop_arbiter #(.DATA_SIZE(DW), .NUM_IN(N), .RR_EN(1'b0)) u_sp (
        .clk       (clk),
        .reset     (reset),
        .in_empty  (in_empty_u[1]),
        .in_data   (in_data_u[1]),
        .out_pause (out_pause),
        .out_full  (out_full),
        .in_pop    (in_pop_u[1]),
        .out_push  (out_push_u[1]),
        .out_data  (out_data_u[1]),
        .grant_idx (grant_u[1]),
        .drop_err  (derr_u[1]),
        .drop_cnt  (dcnt_u[1]),
        .fsm_state (st_u[1])
    );

    // Source FIFO contents and the word each source currently presents.
    logic [DW-1:0] src_q  [NU][N][$];
    logic [DW-1:0] data_r [NU][N];

    // Timeline model: which cycles popped, and the word each pop fetched.
    bit            pop_h  [NU][MAXC];
    logic [DW-1:0] word_h [NU][MAXC];
    arb_state_t    m_mode [NU];
    int            m_ptr  [NU];
    int            m_drops[NU];
    logic          e_push [NU];
    logic [DW-1:0] e_data [NU];
    logic          e_derr [NU];
    logic [1:0]    e_grant[NU];

    int cyc;
    int n_vec;
    int n_err;

    task automatic chk(input string tag, input int u, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s unit%0d cyc=%0d got=%0h exp=%0h", tag, u, cyc, got, exp);
        end
    endtask

    task automatic refresh();
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < N; i++) begin
                in_empty_u[u][i]         = (src_q[u][i].size() == 0);
                in_data_u[u][i*DW +: DW] = data_r[u][i];
            end
        end
    endtask

    task automatic add_word(input int s, input logic [DW-1:0] w);
        for (int u = 0; u < NU; u++) begin
            src_q[u][s].push_back(w);
        end
    endtask

    task automatic step();
        logic [N-1:0] act_pop [NU];
        logic [N-1:0] exp_pop;
        int           pick;
        int           start;
        int           j;
        bit           pv;
        bit           any;
        refresh();
        #1;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        for (int u = 0; u < NU; u++) begin
            pick = -1;
            any  = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (src_q[u][i].size() != 0) any = 1'b1;
            end
            if (!reset && m_mode[u] == ST_RUN && !out_pause) begin
                start = (u == 0) ? m_ptr[u] : 0;
                for (int k = 0; k < N; k++) begin
                    j = (start + k) % N;
                    if (pick < 0 && src_q[u][j].size() != 0) pick = j;
                end
            end
            exp_pop = '0;
            if (pick >= 0) exp_pop[pick] = 1'b1;

            chk("in_pop",    u, 32'(in_pop_u[u]),   32'(exp_pop));
            chk("out_push",  u, 32'(out_push_u[u]), 32'(e_push[u]));
            chk("out_data",  u, 32'(out_data_u[u]), 32'(e_data[u]));
            chk("drop_err",  u, 32'(derr_u[u]),     32'(e_derr[u]));
            chk("drop_cnt",  u, 32'(dcnt_u[u]),     (m_drops[u] > 255) ? 32'd255 : 32'(m_drops[u]));
            chk("grant_idx", u, 32'(grant_u[u]),    32'(e_grant[u]));
            chk("fsm_state", u, 32'(st_u[u]),       32'(m_mode[u]));

            pop_h[u][cyc] = (pick >= 0);
            if (pick >= 0) word_h[u][cyc] = src_q[u][pick][0];

            if (reset) begin
                e_push[u]  = 1'b0;
                e_data[u]  = '0;
                e_derr[u]  = 1'b0;
                e_grant[u] = '0;
                m_drops[u] = 0;
                m_ptr[u]   = 0;
                m_mode[u]  = ST_IDLE;
            end else begin
                pv         = (cyc > 0) && pop_h[u][cyc-1];
                e_push[u]  = pv && !out_full;
                e_derr[u]  = pv && out_full;
                if (e_push[u]) e_data[u] = word_h[u][cyc-1];
                if (e_derr[u]) m_drops[u]++;
                if (pick >= 0) begin
                    e_grant[u] = 2'(pick);
                    m_ptr[u]   = (pick + 1) % N;
                end
                case (m_mode[u])
                    ST_IDLE: if (any) m_mode[u] = ST_RUN;
                    ST_RUN:  if (out_pause) m_mode[u] = ST_HOLD; else if (!any) m_mode[u] = ST_IDLE;
                    default: if (!out_pause) m_mode[u] = ST_RUN;
                endcase
            end
            act_pop[u] = in_pop_u[u];
        end
        @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < N; i++) begin
                if (act_pop[u][i] && src_q[u][i].size() != 0) data_r[u][i] = src_q[u][i].pop_front();
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic rnd(input int n, input int p_pause, input int p_full, input int p_word);
        int s;
        repeat (n) begin
            out_pause = ($urandom_range(0, 99) < p_pause);
            out_full  = ($urandom_range(0, 99) < p_full);
            if ($urandom_range(0, 99) < p_word) begin
                s = $urandom_range(0, N - 1);
                if (src_q[0][s].size() < 8) add_word(s, DW'($urandom_range(0, 1023)));
            end
            step();
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        reset     = 1'b1;
        out_pause = 1'b0;
        out_full  = 1'b0;
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < N; i++) data_r[u][i] = '0;
            m_mode[u]  = ST_IDLE;
            m_ptr[u]   = 0;
            m_drops[u] = 0;
            e_push[u]  = 1'b0;
            e_data[u]  = '0;
            e_derr[u]  = 1'b0;
            e_grant[u] = '0;
        end
        refresh();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then release.
        step();
        reset = 1'b0;
        run(2);

        // Single source word 10'h155 from src0.
        add_word(0, 10'h155);
        run(5);

        // All four sources busy: rotating grants vs. index-0-first.
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < 3; k++) add_word(s, DW'($urandom_range(0, 1023)));
        end
        run(16);

        // Sources 0 and 2 only.
        for (int k = 0; k < 3; k++) begin
            add_word(0, DW'($urandom_range(0, 1023)));
            add_word(2, DW'($urandom_range(0, 1023)));
        end
        run(10);

        // Pause mid-stream, then release.
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < 4; k++) add_word(s, DW'($urandom_range(0, 1023)));
        end
        run(3);
        out_pause = 1'b1;
        run(3);
        out_pause = 1'b0;
        run(20);

        // Downstream full while a word sits in the push stage.
        for (int k = 0; k < 3; k++) add_word(1, DW'($urandom_range(0, 1023)));
        run(2);
        out_full = 1'b1;
        run(1);
        out_full = 1'b0;
        run(6);

        // Random traffic with pause and full.
        rnd(400, 10, 10, 60);
        out_pause = 1'b0;
        out_full  = 1'b0;
        run(30);

        // Long drop run saturates the counter.
        out_full = 1'b1;
        for (int k = 0; k < 80; k++) begin
            for (int s = 0; s < N; s++) add_word(s, DW'($urandom_range(0, 1023)));
        end
        run(330);
        #1;
        for (int u = 0; u < NU; u++) chk("drop_cnt_sat", u, 32'(dcnt_u[u]), 32'd255);
        out_full = 1'b0;
        run(2);

        // Reset while a word is in flight.
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < 3; k++) add_word(s, DW'($urandom_range(0, 1023)));
        end
        run(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
